// File: rtl/eth_switch_pkg.sv
// Shared types and constants for the ethernet switch ingress path.
// Holds the commit controller state type and the FCS verdict encodings.
package eth_switch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_FCS = 2'd1,
    FORWARD  = 2'd2,
    DISCARD  = 2'd3
  } commit_state_t;

  localparam logic [1:0] FCS_PASS = 2'b10;
  localparam logic [1:0] FCS_FAIL = 2'b11;

  // True when the checker has published a verdict (pass or fail).
  function automatic logic fcs_verdict_valid(input logic [1:0] fcs);
    fcs_verdict_valid = (fcs == FCS_PASS) || (fcs == FCS_FAIL);
  endfunction

endpackage

// File: rtl/frame_commit_ctrl_lookup_fifo.sv
// lookup_fifo: small synchronous FIFO holding MAC lookup results until the
// matching FCS verdict arrives. Head data is visible combinationally so the
// consumer can act on it in the pop cycle. A push while full is accepted
// only when a pop happens in the same cycle.
module lookup_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == {(AW + 1){1'b0}});
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Qualify requests: never pop empty, push when full only alongside a pop.
  always_comb begin
    do_pop_s  = 1'b0;
    do_push_s = 1'b0;
    if (pop_i && !empty_o) begin
      do_pop_s = 1'b1;
    end else begin
      do_pop_s = 1'b0;
    end
    if (push_i && (!full_o || do_pop_s)) begin
      do_push_s = 1'b1;
    end else begin
      do_push_s = 1'b0;
    end
  end

  // Storage array and write pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
    end else if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
      wr_ptr_q        <= wr_ptr_q + PTR_ONE;
    end
  end

  // Read pointer advances on every accepted pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= {AW{1'b0}};
    end else if (do_pop_s) begin
      rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= {(AW + 1){1'b0}};
    end else begin
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/frame_commit_ctrl.sv
// frame_commit_ctrl: per-ingress commit/discard controller. Pairs queued MAC
// lookup masks with FCS verdicts in order, steers the frame buffer drain to
// the fabric or to trash, and presents the destination mask while forwarding.
// Optional build macro STATS_EN adds saturating forward/drop counters; when
// it is undefined the counter outputs are tied to zero.
module frame_commit_ctrl
  import eth_switch_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DEPTH     = 2,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   lookup_valid,
  input  logic [NUM_PORTS-1:0]   lookup_mask,
  input  logic [1:0]             fcs_status,
  input  logic                   done,
  output logic                   en,
  output logic                   sel,
  output logic [NUM_PORTS-1:0]   tx_mask,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   lookup_ovf,
  output logic [CNT_W-1:0]       fwd_count,
  output logic [CNT_W-1:0]       drop_count
);

  localparam int PW = $clog2(DEPTH) + 1;

  commit_state_t          state_q;
  logic [NUM_PORTS-1:0]   tx_mask_q;
  logic                   lookup_ovf_q;
  logic                   lookup_ovf_d;
  logic                   pop_s;
  logic [NUM_PORTS-1:0]   head_s;
  logic                   full_s;
  logic                   empty_s;
  logic [PW-1:0]          count_s;

  lookup_fifo #(
    .WIDTH (NUM_PORTS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (lookup_valid),
    .pop_i   (pop_s),
    .wdata_i (lookup_mask),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count_s)
  );

  // Head entry is consumed in the cycle a verdict is seen while waiting.
  always_comb begin
    pop_s = 1'b0;
    if ((state_q == WAIT_FCS) && fcs_verdict_valid(fcs_status) && !empty_s) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // A lookup is lost only when the FIFO is full and nothing leaves this cycle.
  always_comb begin
    lookup_ovf_d = 1'b0;
    if (lookup_valid && full_s && !pop_s) begin
      lookup_ovf_d = 1'b1;
    end else begin
      lookup_ovf_d = 1'b0;
    end
  end

  // Commit FSM; also owns the registered destination mask.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tx_mask_q <= {NUM_PORTS{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (count_s != {PW{1'b0}}) begin
            state_q <= WAIT_FCS;
          end
        end
        WAIT_FCS: begin
          if (fcs_status == FCS_PASS) begin
            if (head_s != {NUM_PORTS{1'b0}}) begin
              state_q   <= FORWARD;
              tx_mask_q <= head_s;
            end else begin
              state_q   <= DISCARD;
              tx_mask_q <= {NUM_PORTS{1'b0}};
            end
          end else if (fcs_status == FCS_FAIL) begin
            state_q   <= DISCARD;
            tx_mask_q <= {NUM_PORTS{1'b0}};
          end
        end
        FORWARD: begin
          if (done) begin
            state_q   <= IDLE;
            tx_mask_q <= {NUM_PORTS{1'b0}};
          end
        end
        DISCARD: begin
          if (done) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          tx_mask_q <= {NUM_PORTS{1'b0}};
        end
      endcase
    end
  end

  // Overflow pulse register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lookup_ovf_q <= 1'b0;
    end else begin
      lookup_ovf_q <= lookup_ovf_d;
    end
  end

  // Drain controls; the fabric path closes in the cycle done arrives.
  always_comb begin
    en  = 1'b0;
    sel = 1'b0;
    case (state_q)
      FORWARD: begin
        en  = 1'b1;
        sel = !done;
      end
      DISCARD: begin
        en  = 1'b1;
        sel = 1'b0;
      end
      default: begin
        en  = 1'b0;
        sel = 1'b0;
      end
    endcase
  end

  assign tx_mask    = tx_mask_q;
  assign pending    = count_s;
  assign lookup_ovf = lookup_ovf_q;

`ifdef STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] fwd_count_q;
  logic [CNT_W-1:0] drop_count_q;
  logic             fwd_inc_s;
  logic             drop_inc_s;

  // Count events: verdict outcomes leaving WAIT_FCS plus dropped lookups.
  always_comb begin
    fwd_inc_s  = 1'b0;
    drop_inc_s = 1'b0;
    if (pop_s && (fcs_status == FCS_PASS) && (head_s != {NUM_PORTS{1'b0}})) begin
      fwd_inc_s = 1'b1;
    end else begin
      fwd_inc_s = 1'b0;
    end
    if ((pop_s && !fwd_inc_s) || lookup_ovf_d) begin
      drop_inc_s = 1'b1;
    end else begin
      drop_inc_s = 1'b0;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_count_q  <= {CNT_W{1'b0}};
      drop_count_q <= {CNT_W{1'b0}};
    end else begin
      if (fwd_inc_s && (fwd_count_q != CNT_MAX)) begin
        fwd_count_q <= fwd_count_q + CNT_ONE;
      end
      if (drop_inc_s && (drop_count_q != CNT_MAX)) begin
        drop_count_q <= drop_count_q + CNT_ONE;
      end
    end
  end

  assign fwd_count  = fwd_count_q;
  assign drop_count = drop_count_q;
`else
  assign fwd_count  = {CNT_W{1'b0}};
  assign drop_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_frame_commit_ctrl.sv
// Scoreboard bench for frame_commit_ctrl: a queue-based reference model
// predicts frame outcomes and overflow pulses; a negedge monitor consumes them.
module tb_frame_commit_ctrl;

  localparam int NP    = 4;
  localparam int DEPTH = 2;
  localparam int CNT_W = 16;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            lookup_valid = 1'b0;
  logic [NP-1:0]   lookup_mask = '0;
  logic [1:0]      fcs_status = 2'b00;
  logic            done = 1'b0;
  logic            en;
  logic            sel;
  logic [NP-1:0]   tx_mask;
  logic [PW-1:0]   pending;
  logic            lookup_ovf;
  logic [CNT_W-1:0] fwd_count;
  logic [CNT_W-1:0] drop_count;

  always #5 clk = ~clk;

  frame_commit_ctrl #(.NUM_PORTS(NP), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .lookup_valid (lookup_valid),
    .lookup_mask  (lookup_mask),
    .fcs_status   (fcs_status),
    .done         (done),
    .en           (en),
    .sel          (sel),
    .tx_mask      (tx_mask),
    .pending      (pending),
    .lookup_ovf   (lookup_ovf),
    .fwd_count    (fwd_count),
    .drop_count   (drop_count)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            fwd;
    logic [NP-1:0] mask;
    int            stamp;
  } frame_t;

  typedef enum {M_IDLE, M_AWAIT_VERDICT, M_SENDING, M_TRASHING} mphase_t;

  frame_t        frq[$];
  int            ovq[$];
  logic [NP-1:0] mq[$];
  mphase_t       mph = M_IDLE;
  int            m_fwd = 0;
  int            m_drop = 0;
  int            exp_pend = 0;
  bit            mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: advance by one clock given the inputs of that cycle.
  task automatic model_step(input bit lv, input logic [NP-1:0] m, input logic [1:0] f, input bit dn);
    frame_t r;
    case (mph)
      M_IDLE: if (mq.size() > 0) mph = M_AWAIT_VERDICT;
      M_AWAIT_VERDICT: begin
        if (f == 2'b10 || f == 2'b11) begin
          r.fwd   = (f == 2'b10) && (mq[0] != '0);
          r.mask  = mq[0];
          r.stamp = cyc + 1;
          void'(mq.pop_front());
          frq.push_back(r);
          if (r.fwd) begin m_fwd++; mph = M_SENDING; end
          else begin m_drop++; mph = M_TRASHING; end
        end
      end
      default: if (dn) mph = M_IDLE;
    endcase
    if (lv) begin
      if (mq.size() < DEPTH) mq.push_back(m);
      else begin ovq.push_back(cyc + 1); m_drop++; end
    end
  endtask

  task automatic cycle(input bit lv, input logic [NP-1:0] m, input logic [1:0] f, input bit dn);
    @(posedge clk);
    #1;
    lookup_valid = lv;
    lookup_mask  = m;
    fcs_status   = f;
    done         = dn;
    exp_pend     = mq.size();
    model_step(lv, m, f, dn);
  endtask

  task automatic drain();
    int n = 0;
    while ((mph != M_IDLE || mq.size() != 0) && n < 50) begin
      cycle(1'b0, '0, 2'b10, 1'b1);
      n++;
    end
    if (n >= 50) check("drain_timeout", 32'd0, 32'd1);
    cycle(1'b0, '0, 2'b00, 1'b0);
    cycle(1'b0, '0, 2'b00, 1'b0);
  endtask

  // Monitor: consumes expected frames/overflows whenever the DUT shows them.
  initial begin
    bit     en_p = 1'b0;
    bit     done_p = 1'b0;
    frame_t cur;
    cur.fwd = 1'b0; cur.mask = '0; cur.stamp = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (en && !en_p) begin
          if (frq.size() == 0) check("spurious_frame_start", 32'd1, 32'd0);
          else begin
            cur = frq.pop_front();
            check("frame_start_cycle", cyc, cur.stamp);
          end
        end
        if (en_p && done_p) check("en_low_after_done", {31'd0, en}, 32'd0);
        else if (en_p) check("en_held_in_frame", {31'd0, en}, 32'd1);
        if (en) begin
          check("sel", {31'd0, sel}, {31'd0, cur.fwd && !done});
          check("tx_mask", {28'd0, tx_mask}, {28'd0, (cur.fwd ? cur.mask : 4'b0000)});
        end else begin
          check("sel_idle", {31'd0, sel}, 32'd0);
          check("tx_mask_idle", {28'd0, tx_mask}, 32'd0);
        end
        if (lookup_ovf) begin
          if (ovq.size() == 0) check("spurious_ovf", 32'd1, 32'd0);
          else check("ovf_cycle", cyc, ovq.pop_front());
        end
        if (frq.size() > 0 && frq[0].stamp < cyc) begin
          check("missed_frame", 32'd0, 32'd1);
          void'(frq.pop_front());
        end
        if (ovq.size() > 0 && ovq[0] < cyc) begin
          check("missed_ovf", 32'd0, 32'd1);
          void'(ovq.pop_front());
        end
        check("pending", {{(32-PW){1'b0}}, pending}, exp_pend);
      end
      en_p   = en;
      done_p = done;
    end
  end

  initial begin
    logic [1:0]    fcs_r;
    logic [NP-1:0] m;
    int            sel_r;
    logic [31:0]   exp_f;
    logic [31:0]   exp_d;

    #1 reset = 1'b1;
    #2;
    check("reset_en", {31'd0, en}, 32'd0);
    check("reset_sel", {31'd0, sel}, 32'd0);
    check("reset_tx_mask", {28'd0, tx_mask}, 32'd0);
    check("reset_pending", {{(32-PW){1'b0}}, pending}, 32'd0);
    check("reset_ovf", {31'd0, lookup_ovf}, 32'd0);
    check("reset_fwd_count", {16'd0, fwd_count}, 32'd0);
    check("reset_drop_count", {16'd0, drop_count}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Forward a single frame, done five cycles into FORWARD.
    cycle(1'b1, 4'b0100, 2'b00, 1'b0);
    cycle(1'b0, 4'b0000, 2'b00, 1'b0);
    cycle(1'b0, 4'b0000, 2'b10, 1'b0);
    repeat (5) cycle(1'b0, 4'b0000, 2'b10, 1'b0);
    cycle(1'b0, 4'b0000, 2'b10, 1'b1);
    repeat (2) cycle(1'b0, 4'b0000, 2'b00, 1'b0);

    // Bad FCS discards.
    cycle(1'b1, 4'b0010, 2'b00, 1'b0);
    cycle(1'b0, 4'b0000, 2'b00, 1'b0);
    cycle(1'b0, 4'b0000, 2'b11, 1'b0);
    repeat (3) cycle(1'b0, 4'b0000, 2'b11, 1'b0);
    cycle(1'b0, 4'b0000, 2'b00, 1'b1);
    repeat (2) cycle(1'b0, 4'b0000, 2'b00, 1'b0);

    // Good FCS but no destination discards.
    cycle(1'b1, 4'b0000, 2'b00, 1'b0);
    cycle(1'b0, 4'b0000, 2'b00, 1'b0);
    cycle(1'b0, 4'b0000, 2'b10, 1'b0);
    repeat (2) cycle(1'b0, 4'b0000, 2'b00, 1'b0);
    cycle(1'b0, 4'b0000, 2'b00, 1'b1);
    repeat (2) cycle(1'b0, 4'b0000, 2'b00, 1'b0);

    // Three back-to-back lookups overflow a two-entry FIFO.
    cycle(1'b1, 4'b0001, 2'b00, 1'b0);
    cycle(1'b1, 4'b1000, 2'b00, 1'b0);
    cycle(1'b1, 4'b0110, 2'b00, 1'b0);
    repeat (2) cycle(1'b0, 4'b0000, 2'b00, 1'b0);
    drain();

    // Push coinciding with pop while full.
    cycle(1'b1, 4'b0011, 2'b00, 1'b0);
    cycle(1'b1, 4'b0101, 2'b00, 1'b0);
    cycle(1'b0, 4'b0000, 2'b00, 1'b0);
    cycle(1'b1, 4'b1100, 2'b10, 1'b0);
    cycle(1'b0, 4'b0000, 2'b00, 1'b0);
    @(negedge clk);
    check("push_pop_full_pending", {{(32-PW){1'b0}}, pending}, 32'd2);
    check("push_pop_full_no_ovf", {31'd0, lookup_ovf}, 32'd0);
    drain();

    // Randomized traffic.
    fcs_r = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      sel_r = $urandom_range(0, 7);
      if (sel_r == 0) m = 4'b0000;
      else if (sel_r == 1) m = 4'b1111;
      else m = NP'($urandom);
      if ($urandom_range(0, 3) == 0) fcs_r = 2'($urandom_range(0, 3));
      cycle($urandom_range(0, 99) < 35, m, fcs_r, $urandom_range(0, 99) < 30);
    end
    drain();

    @(negedge clk);
    check("frames_all_seen", frq.size(), 32'd0);
    check("ovf_all_seen", ovq.size(), 32'd0);
`ifdef STATS_EN
    exp_f = m_fwd;
    exp_d = m_drop;
`else
    exp_f = 32'd0;
    exp_d = 32'd0;
`endif
    check("fwd_count", {16'd0, fwd_count}, exp_f);
    check("drop_count", {16'd0, drop_count}, exp_d);

    // Asynchronous reset in the middle of a forwarded frame.
    mon_en = 1'b0;
    cycle(1'b1, 4'b1000, 2'b00, 1'b0);
    cycle(1'b1, 4'b0001, 2'b00, 1'b0);
    cycle(1'b0, 4'b0000, 2'b10, 1'b0);
    cycle(1'b0, 4'b0000, 2'b00, 1'b0);
    #1;
    check("pre_reset_fwd_en", {31'd0, en}, 32'd1);
    check("pre_reset_tx_mask", {28'd0, tx_mask}, 32'b1000);
    reset = 1'b1;
    #1;
    check("async_reset_en", {31'd0, en}, 32'd0);
    check("async_reset_sel", {31'd0, sel}, 32'd0);
    check("async_reset_tx_mask", {28'd0, tx_mask}, 32'd0);
    check("async_reset_pending", {{(32-PW){1'b0}}, pending}, 32'd0);
    check("async_reset_fwd_count", {16'd0, fwd_count}, 32'd0);
    check("async_reset_drop_count", {16'd0, drop_count}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      lookup_valid = 1'b0;
      fcs_status   = 2'b10;
      done         = 1'b0;
      @(negedge clk);
      check("post_reset_en", {31'd0, en}, 32'd0);
      check("post_reset_tx_mask", {28'd0, tx_mask}, 32'd0);
      check("post_reset_pending", {{(32-PW){1'b0}}, pending}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
